// File: rtl/addr_seq_mem_if.sv
// Bus bundle for the sequential-address memory.
// Master drives enables and data; slave returns address and read data.
interface addr_seq_mem_if #(
  parameter int aw = 8,
  parameter int dw = 16
);
  logic          wex;
  logic          rex;
  logic [dw-1:0] wdata;
  logic [aw-1:0] addr;
  logic [dw-1:0] rdata;

  modport master (
    output wex,
    output rex,
    output wdata,
    input  addr,
    input  rdata
  );

  modport slave (
    input  wex,
    input  rex,
    input  wdata,
    output addr,
    output rdata
  );
endinterface

// File: rtl/addr_seq_mem.sv
// Sequential-address memory: free-running counter sweeps a
// single-port RAM; writes land at the pre-edge address.
module addr_seq_mem #(
  parameter int aw = 8,
  parameter int dw = 16
) (
  input  logic           clk,
  input  logic           rst,
  addr_seq_mem_if.slave  bus
);
  localparam int depth = 2 ** aw;

  logic [aw-1:0] addr;
  logic [dw-1:0] mem [depth];

  // Address counter: cleared asynchronously, wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr <= '0;
    end else begin
      addr <= addr + 1'b1;
    end
  end

  // Storage write; contents survive reset, unknown wex never writes.
  always_ff @(posedge clk) begin
    if (rst && (bus.wex == 1'b0)) begin
      mem[addr] <= bus.wdata;
    end
  end

  // Zero-latency read, forced to zero when not enabled.
  always_comb begin
    bus.rdata = '0;
    if (bus.rex == 1'b0) begin
      bus.rdata = mem[addr];
    end
  end

  assign bus.addr = addr;
endmodule

// File: tb/tb_addr_seq_mem.sv
// Randomised and directed bench for addr_seq_mem against a
// behavioural model of the address sweep and memory contents.
module tb_addr_seq_mem;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  addr_seq_mem_if #(.aw(8), .dw(16)) bus ();

  addr_seq_mem #(.aw(8), .dw(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: current address and known memory words.
  int          m_addr;
  logic [15:0] m_mem [256];
  bit          m_valid [256];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: counter steps each edge out of reset, write at old addr.
  always @(posedge clk) begin
    if (rst === 1'b1) begin
      if (bus.wex === 1'b0) begin
        m_mem[m_addr]   = bus.wdata;
        m_valid[m_addr] = 1'b1;
      end
      m_addr = (m_addr + 1) % 256;
    end
  end

  always @(negedge rst) m_addr = 0;

  // Compare DUT with the model every cycle, away from the edge.
  always @(negedge clk) begin
    chk("model_addr", {24'h0, bus.addr}, m_addr);
    if (bus.rex === 1'b1) begin
      chk("model_rdata_off", {16'h0, bus.rdata}, 32'h0);
    end else if (m_valid[m_addr]) begin
      chk("model_rdata", {16'h0, bus.rdata},
          {16'h0, m_mem[m_addr]});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    m_addr    = 0;
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
    rst       = 1'b0;
    bus.wex   = 1'b1;
    bus.rex   = 1'b1;
    bus.wdata = '0;

    tick();
    tick();
    #2 chk("reset_addr", {24'h0, bus.addr}, 32'h0);
    chk("reset_rdata", {16'h0, bus.rdata}, 32'h0);
    rst = 1'b1;

    for (int i = 0; i < 8'h37; i++) tick();
    #1 chk("count_37", {24'h0, bus.addr}, 32'h37);
    rst = 1'b0;
    #1 chk("async_clear", {24'h0, bus.addr}, 32'h0);
    for (int i = 0; i < 3; i++) tick();
    #2 chk("held_in_reset", {24'h0, bus.addr}, 32'h0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    #2 chk("three_after_release", {24'h0, bus.addr}, 32'h3);

    rst = 1'b0;
    #1 rst = 1'b1;
    for (int i = 0; i < 255; i++) tick();
    #2 chk("wrap_ff", {24'h0, bus.addr}, 32'hff);
    tick();
    #2 chk("wrap_00", {24'h0, bus.addr}, 32'h0);

    for (int i = 0; i < 256; i++) begin
      bus.wex   = 1'b0;
      bus.rex   = 1'b1;
      bus.wdata = 16'(i);
      tick();
    end
    bus.wex = 1'b1;

    bus.rex = 1'b0;
    for (int i = 0; i < 256; i++) begin
      #2 chk("readback_addr", {24'h0, bus.addr}, i);
      chk("readback", {16'h0, bus.rdata}, i);
      tick();
    end

    bus.rex   = 1'b1;
    bus.wdata = 16'hffff;
    for (int i = 0; i < 256; i++) tick();
    bus.rex = 1'b0;
    for (int i = 0; i < 256; i++) begin
      #2 chk("inhibit", {16'h0, bus.rdata}, i);
      tick();
    end

    rst       = 1'b0;
    bus.wex   = 1'b0;
    bus.wdata = 16'haaaa;
    for (int i = 0; i < 4; i++) tick();
    #2 chk("reset_no_write", {16'h0, bus.rdata}, 32'h0);
    bus.wex = 1'b1;
    rst     = 1'b1;
    #1 chk("retain_00", {16'h0, bus.rdata}, 32'h0);
    for (int i = 0; i < 16; i++) tick();
    #2 chk("retain_addr_10", {24'h0, bus.addr}, 32'h10);
    chk("retain_10", {16'h0, bus.rdata}, 32'h10);

    for (int n = 0; n < 3000; n++) begin
      bus.wex   = 1'($urandom_range(0, 1));
      bus.rex   = 1'($urandom_range(0, 1));
      bus.wdata = 16'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        #1 rst = 1'b0;
        #2 rst = 1'b1;
      end
      tick();
    end

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/addr_seq_mem.md
Name: addr_seq_mem

Overview:
- Sequential-address memory block: a free-running address counter (ia function) steps through every word of a single-port RAM (mem function) once per clock.
- Writes store wdata at the current counter address; reads present the word at the current address.
- Used for memory fill/scan in bring-up and test: sweeps the whole array with no external address bus.
- One clock domain.

Parameters:
- aw, 8, address width; memory depth is 2**aw words.
- dw, 16, data word width.

Ports:
- clk    input   1    system clock, all state updates on rising edge.
- rst    input   1    reset, asynchronous assert, active-low (0 = reset); synchronous release on clk.
- wex    input   1    write enable, active-low (0 = write this cycle).
- rex    input   1    read enable, active-low (0 = drive rdata).
- wdata  input   dw   write data.
- addr   output  aw   current address counter value (ia output, also the RAM address).
- rdata  output  dw   read data.

Behaviour:
- Reset (rst=0):
  - addr forced to 0 immediately, without waiting for clk, and held while rst=0.
  - Writes are inhibited during reset.
  - Memory contents are not cleared by reset; a mid-run reset retains all stored words.
  - Power-up memory contents are undefined; the bench must write before reading.
- Address counter:
  - On each rising clk edge with rst=1: addr <= addr + 1, modulo 2**aw.
  - 2**aw-1 wraps to 0; no terminal flag.
  - The counter runs regardless of wex/rex.
  - The first edge after rst goes high moves addr from 0 to 1.
- Write:
  - On a rising clk edge with rst=1 and wex=0: mem[addr] <= wdata.
  - addr here is the value before the edge; the counter advances on the same edge.
  - wex=1 means no write.
  - X/Z on wex is treated as no write.
- Read:
  - Combinational, zero latency.
  - rex=0: rdata = mem[addr].
  - rex=1: rdata = all zeros.
  - rdata follows addr changes within the same cycle.
- Simultaneous read and write to the same address:
  - Before the edge, rdata shows the old word.
  - After the edge, addr has advanced, so rdata shows the next location; no write-through path.
- Data width: wdata stored exactly as dw bits, no truncation or extension.
- Storage: 2**aw by dw register array, or an inferred RAM with asynchronous read.

Test Plan:
- Reset/async: drive rst=0 mid-count with addr=0x37 -> addr=0x00 before the next clk edge, and stays 0 while rst=0. Release rst, then 3 edges -> addr=0x03.
- Wrap: with rst=1, count 255 edges from 0 -> addr=0xFF. The next edge -> addr=0x00.
- Fill and readback:
  - Fill: wex=0, rex=1, with wdata set each cycle to the current addr (zero-extended) for 256 cycles -> rdata=0x0000 throughout.
  - Readback: wex=1, rex=0 for 256 cycles -> rdata==addr for every address 0x00..0xFF.
- Write inhibit: wex=1 with wdata=0xFFFF for a full sweep -> readback still equals the prior pattern.
- Write during reset: rst=0 with wex=0 and wdata=0xAAAA for several edges -> mem[0] unchanged.
- Reset retention: after the fill, pulse rst low then high, rex=0 -> rdata at addr 0x00 = 0x0000 and at 0x10 = 0x0010; contents preserved.
